// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/response handshake bundle for alu_exec
//
// Purpose: groups the operation request channel and the result channel of
// alu_exec so that producer and consumer connect through one port.
// Signals:
//   in_valid / in_ready       request handshake (master drives in_valid)
//   alu_ctrl                  {funct7[5], funct3} operation code
//   op_a / op_b               operands, sampled only when a request is accepted
//   out_valid / out_ready     result handshake (slave drives out_valid)
//   result / zero             registered result and its zero flag
// Modports: master = issuing pipeline stage, slave = alu_exec.

interface alu_exec_if #(
  parameter int REG_DATA_WIDTH = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                alu_ctrl;
  logic [REG_DATA_WIDTH-1:0] op_a;
  logic [REG_DATA_WIDTH-1:0] op_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [REG_DATA_WIDTH-1:0] result;
  logic                      zero;

  modport master (
    output in_valid,
    output alu_ctrl,
    output op_a,
    output op_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  alu_ctrl,
    input  op_a,
    input  op_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero
  );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - integer ALU execute stage with serial shifter
//
// Purpose: executes one {funct7[5], funct3} ALU operation per accepted
// request. Logic and arithmetic ops finish in one cycle; shifts walk one bit
// position per cycle through an accumulator.
// Ports:
//   clk     clock
//   nreset  asynchronous, active-low reset
//   bus     alu_exec_if.slave: in_valid/in_ready/alu_ctrl/op_a/op_b request,
//           out_valid/out_ready/result/zero response

module alu_exec #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int SHAMT_WIDTH    = 5
) (
  input  logic       clk,
  input  logic       nreset,
  alu_exec_if.slave  bus
);

  localparam int W = REG_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [W-1:0]           acc;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   shift_left;
  logic                   shift_arith;
  logic [W-1:0]           result_q;
  logic                   zero_q;
  logic                   out_valid_q;

  logic                   accept;
  logic                   is_shift;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W-1:0]           op_result;
  logic [W-1:0]           acc_next;

  // A new op may enter while idle, or while the current result is being
  // taken this very cycle (handoff keeps 1 op/cycle throughput).
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // SLL (x001) and SRL/SRA (x101) are the only serial ops.
  assign is_shift = (bus.alu_ctrl[1:0] == 2'b01);
  assign shamt    = bus.op_b[SHAMT_WIDTH-1:0];

  // Single-cycle datapath. For shift codes this yields op_a unchanged, which
  // is exactly the shamt=0 result; nonzero shifts go through the accumulator.
  always_comb begin
    op_result = '0;
    unique case (bus.alu_ctrl[2:0])
      3'b000: op_result = bus.alu_ctrl[3] ? (bus.op_a - bus.op_b)
                                          : (bus.op_a + bus.op_b);
      3'b001: op_result = bus.op_a;
      3'b010: op_result = {{(W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      3'b011: op_result = {{(W-1){1'b0}}, (bus.op_a < bus.op_b)};
      3'b100: op_result = bus.op_a ^ bus.op_b;
      3'b101: op_result = bus.op_a;
      3'b110: op_result = bus.op_a | bus.op_b;
      3'b111: op_result = bus.op_a & bus.op_b;
      default: op_result = '0;
    endcase
  end

  // One bit position per cycle; SRA fill replicates the current MSB.
  always_comb begin
    acc_next = '0;
    if (shift_left) begin
      acc_next = {acc[W-2:0], 1'b0};
    end else begin
      acc_next = {shift_arith & acc[W-1], acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              acc         <= bus.op_a;
              count       <= shamt;
              shift_left  <= ~bus.alu_ctrl[2];
              shift_arith <= bus.alu_ctrl[2] & bus.alu_ctrl[3];
              out_valid_q <= 1'b0;
              state       <= SHIFT;
            end else begin
              result_q    <= op_result;
              zero_q      <= (op_result == '0);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            // Result consumed with nothing new; result_q keeps its value.
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        SHIFT: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == 1) begin
            result_q    <= acc_next;
            zero_q      <= (acc_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec

module tb_alu_exec;

  logic clk;
  logic nreset;
  int   checks;
  int   errors;

  alu_exec_if #(.REG_DATA_WIDTH(32)) ifc ();

  alu_exec #(.REG_DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what each code means in plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] ctrl,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (ctrl[2:0])
      3'd0: return ctrl[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return ctrl[3] ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] ctrl, input logic [31:0] b);
    if ((ctrl[2:0] == 3'd1 || ctrl[2:0] == 3'd5) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string name);
    int lat;
    int exp_lat;
    int k;
    exp_lat = model_latency(ctrl, b);
    @(negedge clk);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = ctrl;
    ifc.op_a      = a;
    ifc.op_b      = b;
    #1;
    k = 0;
    while (ifc.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk); #1; k++;
    end
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, ifc.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    // Garbage after accept must not disturb the op in flight.
    ifc.in_valid = 1'b0;
    ifc.alu_ctrl = 4'($urandom);
    ifc.op_a     = $urandom;
    ifc.op_b     = $urandom;
    #1;
    lat = 1;
    while (ifc.out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy: in_ready=%b required 0 at cycle %0d", name, ifc.in_ready, lat);
      end
      @(negedge clk); #1; lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (ifc.result !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h required %h", name, ifc.result, exp);
    end
    checks++;
    if (ifc.zero !== (exp == 32'd0)) begin
      errors++;
      $display("FAIL %s_zero: got %b required %b", name, ifc.zero, (exp == 32'd0));
    end
    @(negedge clk); #1;
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b required 0", name, ifc.out_valid);
    end
  endtask

  task automatic test_reset;
    nreset        = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.alu_ctrl  = 4'd0;
    ifc.op_a      = 32'd0;
    ifc.op_b      = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", ifc.out_valid);
    end
    checks++;
    if (ifc.result !== 32'd0) begin
      errors++; $display("FAIL reset_result: got %h required 0", ifc.result);
    end
    checks++;
    if (ifc.zero !== 1'b0) begin
      errors++; $display("FAIL reset_zero: got %b required 0", ifc.zero);
    end
    nreset = 1'b1;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", ifc.in_ready);
    end
  endtask

  task automatic test_add_sub_back_to_back;
    @(negedge clk);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = 4'b0000;
    ifc.op_a      = 32'd5;
    ifc.op_b      = 32'd7;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.result !== 32'h0000000C || ifc.zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_add: valid=%b result=%h zero=%b required 1 0000000c 0",
               ifc.out_valid, ifc.result, ifc.zero);
    end
    ifc.alu_ctrl = 4'b1000;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_handoff_ready: got %b required 1", ifc.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.result !== 32'hFFFFFFFE || ifc.zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sub: valid=%b result=%h zero=%b required 1 fffffffe 0",
               ifc.out_valid, ifc.result, ifc.zero);
    end
    ifc.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid=%b required 0", ifc.out_valid);
    end
  endtask

  task automatic test_compare;
    run_op(4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, "slt");
    run_op(4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, "sltu");
  endtask

  task automatic test_serial_shift;
    run_op(4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, "sra");
    run_op(4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, "srl");
    run_op(4'b0001, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, "sll_shamt0");
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = 4'b0001;
    ifc.op_a      = 32'd1;
    ifc.op_b      = 32'd31;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    lat = 1;
    while (ifc.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != 32) begin
      errors++; $display("FAIL bp_latency: got %0d required 32", lat);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.result !== 32'h80000000 || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b result=%h in_ready=%b required 1 80000000 0",
                 i, ifc.out_valid, ifc.result, ifc.in_ready);
      end
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.result !== 32'h80000000) begin
      errors++;
      $display("FAIL bp_release: valid=%b result=%h required 0 80000000",
               ifc.out_valid, ifc.result);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    @(negedge clk);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = 4'b0101;
    ifc.op_a      = $urandom | 32'h1;
    ifc.op_b      = 32'd20;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (ifc.out_valid === 1'b1) seen = 1'b1;
    end
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b required 1", ifc.in_ready);
    end
    repeat (25) begin
      @(negedge clk);
      if (ifc.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrst_no_valid: out_valid rose, required never");
    end
    run_op(4'b0100, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, "xor_after_reset");
  endtask

  task automatic test_random_ops;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      c = 4'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) a = 32'($urandom_range(0, 3));
      if (i % 4 == 1) b = a;
      run_op(c, a, b, model(c, a, b), "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        took;
    int          accepted;
    int          cyc;
    accepted = 0;
    cyc      = 0;
    @(negedge clk);
    c = 4'($urandom); a = $urandom; b = $urandom;
    ifc.in_valid = 1'b1; ifc.alu_ctrl = c; ifc.op_a = a; ifc.op_b = b;
    while ((accepted < 40 || q.size() != 0) && cyc < 3000) begin
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      if (accepted >= 40) ifc.in_valid = 1'b0;
      #1;
      if (ifc.out_valid === 1'b1 && ifc.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected result %h", ifc.result);
        end else begin
          if (ifc.result !== q[0] || ifc.zero !== (q[0] == 32'd0)) begin
            errors++;
            $display("FAIL stream_result: got %h zero=%b required %h zero=%b",
                     ifc.result, ifc.zero, q[0], (q[0] == 32'd0));
          end
          void'(q.pop_front());
        end
      end
      took = ifc.in_valid && (ifc.in_ready === 1'b1);
      if (took) begin
        q.push_back(model(c, a, b));
        accepted++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (took || !ifc.in_valid) begin
        c = 4'($urandom); a = $urandom; b = $urandom;
        if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 3));
        ifc.in_valid = ($urandom_range(0, 4) != 0);
        ifc.alu_ctrl = c; ifc.op_a = a; ifc.op_b = b;
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    checks++;
    if (q.size() != 0 || cyc >= 3000) begin
      errors++;
      $display("FAIL stream_drain: %0d results outstanding after %0d cycles, required 0", q.size(), cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub_back_to_back();
    test_compare();
    test_serial_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_random_ops();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
